// File: rtl/rst_sequencer.sv
// Staged reset sequencer: releases memory, then peripheral, then CPU domain resets and records the last reset cause.
// Optional watchdog is built when RST_SEQ_WDT_EN is defined.
module rst_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned WDT_CYCLES     = 1048576
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       ext_rst_n_i,
  input  logic       sw_rst_req_i,
  input  logic       lock_i,
  input  logic       wdt_kick_i,
  output logic       mem_rst_o,
  output logic       periph_rst_o,
  output logic       cpu_rst_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {HOLD, WAIT_LOCK, REL_MEM, REL_PERIPH, RUN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   ext_trig_c;
  logic                   lock_trig_c;
  logic                   wdt_trig_c;
  logic                   trig_c;
  logic [1:0]             cause_c;

  // Button synchronizer; flops idle at 1 (button released)
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) ext_sync <= '1;
    else          ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n_i};
  end

  assign ext_trig_c  = ~ext_sync[SYNC_STAGES-1];
  assign lock_trig_c = ~lock_i && ((state == REL_MEM) || (state == REL_PERIPH) || (state == RUN));

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // Counts only while running; a kick on the expiry cycle still wins
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state != RUN) || wdt_kick_i) wdt_cnt <= '0;
    else                                          wdt_cnt <= wdt_cnt + WDT_W'(1);
  end

  assign wdt_trig_c = (state == RUN) && ~wdt_kick_i && (wdt_cnt == WDT_LAST);
`else
  localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
  logic unused_wdt_kick;

  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_trig_c      = 1'b0;
`endif

  assign trig_c = wb_rst_i | lock_trig_c | ext_trig_c | wdt_trig_c | sw_rst_req_i;

  // Cause of the highest-priority active trigger
  always_comb begin
    cause_c = 2'b10;
    if (wb_rst_i || lock_trig_c) cause_c = 2'b00;
    else if (ext_trig_c)         cause_c = 2'b01;
    else if (wdt_trig_c)         cause_c = 2'b11;
  end

  always_ff @(posedge wb_clk_i) begin
    if (trig_c) begin
      state        <= HOLD;
      cnt          <= HOLD_LOAD;
      mem_rst_o    <= 1'b1;
      periph_rst_o <= 1'b1;
      cpu_rst_o    <= 1'b1;
      rst_done_o   <= 1'b0;
      rst_cause_o  <= cause_c;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == '0) state <= WAIT_LOCK;
          else           cnt   <= cnt - CNT_W'(1);
        end
        WAIT_LOCK: begin
          if (lock_i) begin
            state     <= REL_MEM;
            mem_rst_o <= 1'b0;
            cnt       <= STAGGER_LOAD;
          end
        end
        REL_MEM: begin
          if (cnt == '0) begin
            state        <= REL_PERIPH;
            periph_rst_o <= 1'b0;
            cnt          <= STAGGER_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REL_PERIPH: begin
          if (cnt == '0) begin
            state      <= RUN;
            cpu_rst_o  <= 1'b0;
            rst_done_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: ;
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed vector table, then randomized traffic against a
// timestamp-based reference model.
module tb_rst_sequencer;

  localparam int H    = 16;
  localparam int S    = 8;
  localparam int SYNC = 2;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
  localparam int W      = 64;
`else
  localparam bit WDT_ON = 1'b0;
  localparam int W      = 1048576;
`endif

  logic       clk = 1'b0;
  logic       wb_rst, ext_n, sw_req, lock, kick;
  logic       mem_rst, periph_rst, cpu_rst, done;
  logic [1:0] cause;

  rst_sequencer #(
    .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .SYNC_STAGES(SYNC), .WDT_CYCLES(W)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst), .ext_rst_n_i(ext_n), .sw_rst_req_i(sw_req),
    .lock_i(lock), .wdt_kick_i(kick), .mem_rst_o(mem_rst), .periph_rst_o(periph_rst),
    .cpu_rst_o(cpu_rst), .rst_done_o(done), .rst_cause_o(cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: everything follows from the last trigger edge and the memory release edge
  int         n       = 0;
  int         t_trig  = 0;
  int         rel_e   = -1;
  int         wdt_base = 0;
  logic [1:0] m_cause = 2'b00;
  bit         ext_q[$];
  logic [5:0] exp_vec;

  typedef struct {
    logic       wb, extn, sw, lk, kk;
    int         cyc;
    logic [5:0] exp;   // {mem, periph, cpu, done, cause}
  } row_t;
  row_t rows[$];

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_edge(input logic wb, input logic extn, input logic sw, input logic lk,
                            input logic kk);
    bit ext_s, lock_loss, in_run, wdt_fire, trig;
    n++;
    ext_s = ext_q.pop_front();
    ext_q.push_back(extn);
    if (wb) begin
      ext_q.delete();
      repeat (SYNC) ext_q.push_back(1'b1);
    end
    in_run    = (rel_e >= 0) && (n > rel_e + 2*S);
    lock_loss = !lk && (rel_e >= 0) && (n > rel_e);
    wdt_fire  = WDT_ON && in_run && !kk && (n - wdt_base == W);
    trig      = wb || lock_loss || !ext_s || wdt_fire || sw;
    if (trig) begin
      if (wb || lock_loss) m_cause = 2'b00;
      else if (!ext_s)     m_cause = 2'b01;
      else if (wdt_fire)   m_cause = 2'b11;
      else                 m_cause = 2'b10;
      t_trig = n;
      rel_e  = -1;
    end else begin
      if (rel_e < 0 && n >= t_trig + H + 1 && lk) rel_e = n;
      if (in_run && kk) wdt_base = n;
    end
    if (rel_e >= 0 && n == rel_e + 2*S) wdt_base = n;
    exp_vec = {rel_e < 0,
               !(rel_e >= 0 && n >= rel_e + S),
               !(rel_e >= 0 && n >= rel_e + 2*S),
               (rel_e >= 0 && n >= rel_e + 2*S),
               m_cause};
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge
  task automatic step(input logic wb, input logic extn, input logic sw, input logic lk,
                      input logic kk);
    wb_rst = wb; ext_n = extn; sw_req = sw; lock = lk; kick = kk;
    @(posedge clk);
    model_edge(wb, extn, sw, lk, kk);
    #1;
    chk("model", {mem_rst, periph_rst, cpu_rst, done, cause}, exp_vec);
  endtask

  function automatic void add(input logic wb, input logic extn, input logic sw, input logic lk,
                              input int cyc, input logic [5:0] exp);
    row_t r;
    r.wb = wb; r.extn = extn; r.sw = sw; r.lk = lk; r.kk = 1'b0; r.cyc = cyc; r.exp = exp;
    rows.push_back(r);
  endfunction

  initial begin
    int ext_low, lock_low;
    logic r_wb, r_sw, r_kk;
    repeat (SYNC) ext_q.push_back(1'b1);
    wb_rst = 1'b1; ext_n = 1'b1; sw_req = 1'b0; lock = 1'b1; kick = 1'b0;

    //   wb    extn  sw    lock  cycles  {mem,per,cpu,done,cause}
    add(1'b1, 1'b1, 1'b0, 1'b1,  4, 6'b111000);  // power-on reset
    add(1'b0, 1'b1, 1'b0, 1'b1, 16, 6'b111000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b011000);  // memory released after edge 17
    add(1'b0, 1'b1, 1'b0, 1'b1,  7, 6'b011000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b001000);  // peripherals after edge 25
    add(1'b0, 1'b1, 1'b0, 1'b1,  7, 6'b001000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b000100);  // CPU + done after edge 33
    add(1'b0, 1'b1, 1'b1, 1'b1,  1, 6'b111010);  // software reset from RUN
    add(1'b0, 1'b1, 1'b0, 1'b1, 16, 6'b111010);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b011010);
    add(1'b0, 1'b1, 1'b0, 1'b1,  8, 6'b001010);  // now in REL_PERIPH
    add(1'b0, 1'b1, 1'b1, 1'b1,  1, 6'b111010);  // software reset mid-release
    add(1'b0, 1'b1, 1'b0, 1'b1, 33, 6'b000110);
    add(1'b0, 1'b1, 1'b0, 1'b0,  1, 6'b111000);  // lock loss in RUN
    add(1'b0, 1'b1, 1'b0, 1'b0, 30, 6'b111000);  // parked waiting for lock
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b011000);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16, 6'b000100);
    add(1'b0, 1'b0, 1'b0, 1'b1,  2, 6'b000100);  // button: synchronizer latency
    add(1'b0, 1'b0, 1'b0, 1'b1,  1, 6'b111001);
    add(1'b0, 1'b0, 1'b0, 1'b1,  7, 6'b111001);
    add(1'b0, 1'b1, 1'b0, 1'b1, 18, 6'b111001);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b011001);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16, 6'b000101);
    add(1'b0, 1'b0, 1'b0, 1'b1,  2, 6'b000101);  // button and software together
    add(1'b0, 1'b0, 1'b1, 1'b1,  1, 6'b111001);
    add(1'b0, 1'b1, 1'b0, 1'b1, 19, 6'b011001);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16, 6'b000101);
    add(1'b1, 1'b1, 1'b0, 1'b0,  3, 6'b111000);  // late lock
    add(1'b0, 1'b1, 1'b0, 1'b0, 40, 6'b111000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b011000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  8, 6'b001000);
    add(1'b0, 1'b1, 1'b0, 1'b1,  8, 6'b000100);
`ifdef RST_SEQ_WDT_EN
    add(1'b0, 1'b1, 1'b0, 1'b1, 63, 6'b000100);  // unkicked watchdog
    add(1'b0, 1'b1, 1'b0, 1'b1,  1, 6'b111011);
    add(1'b0, 1'b1, 1'b0, 1'b1, 33, 6'b000111);
`endif

    foreach (rows[i]) begin
      for (int c = 0; c < rows[i].cyc; c++)
        step(rows[i].wb, rows[i].extn, rows[i].sw, rows[i].lk, rows[i].kk);
      chk($sformatf("row%0d", i), {mem_rst, periph_rst, cpu_rst, done, cause}, rows[i].exp);
    end

`ifdef RST_SEQ_WDT_EN
    // Regular kicks keep the system running
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, (i % 50) == 0);
      chk("wdt_kicked", {5'b0, done}, 6'd1);
    end
`endif

    // Randomized triggers against the model
    ext_low = 0; lock_low = 0;
    for (int i = 0; i < 5000; i++) begin
      r_wb = ($urandom_range(0, 599) == 0);
      r_sw = ($urandom_range(0, 249) == 0);
      if (ext_low > 0) ext_low--;
      else if ($urandom_range(0, 299) == 0) ext_low = $urandom_range(1, 12);
      if (lock_low > 0) lock_low--;
      else if ($urandom_range(0, 299) == 0) lock_low = $urandom_range(1, 30);
      r_kk = WDT_ON ? ($urandom_range(0, 79) == 0) : 1'($urandom_range(0, 1));
      step(r_wb, ext_low == 0, r_sw, lock_low == 0, r_kk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Reset sequencer driven by the board clock/reset unit. Turns the raw Wishbone clock and reset, an external reset button, a software reset request and a clock-lock indication into three staged, synchronous, active-high domain resets. Reset release order is memory, then peripherals, then CPU. Also reports the cause of the last reset.

## Interface
Parameters:
- HOLD_CYCLES, 16: minimum cycles all resets stay asserted after the last active trigger; must be ≥1.
- STAGGER_CYCLES, 8: cycles between successive domain releases; must be ≥1.
- SYNC_STAGES, 2: flip-flop stages on ext_rst_n_i; must be ≥2.
- WDT_CYCLES, 1048576: watchdog timeout in cycles; used only with RST_SEQ_WDT_EN.

Ports:
- wb_clk_i, in, 1: system clock; the only clock.
- wb_rst_i, in, 1: synchronous, active-high reset; highest-priority trigger.
- ext_rst_n_i, in, 1: asynchronous, active-low button; synchronized internally.
- sw_rst_req_i, in, 1: synchronous software reset request; one-cycle pulse.
- lock_i, in, 1: clock-lock status; synchronous to wb_clk_i.
- wdt_kick_i, in, 1: watchdog kick pulse; ignored without RST_SEQ_WDT_EN.
- mem_rst_o, out, 1: memory-domain reset, active-high.
- periph_rst_o, out, 1: peripheral-domain reset, active-high.
- cpu_rst_o, out, 1: CPU-domain reset, active-high.
- rst_done_o, out, 1: high only in RUN.
- rst_cause_o, out, 2: cause of the last reset: 00 = power/lock, 01 = external, 10 = software, 11 = watchdog.

## Operation
- Triggers:
  - wb_rst_i = 1;
  - synchronized ext_rst_n_i = 0;
  - sw_rst_req_i = 1;
  - lock_i = 0 in any state after WAIT_LOCK (REL_MEM, REL_PERIPH, RUN);
  - watchdog expiry.
- Trigger priority for rst_cause_o: wb_rst_i and lock loss (00) > external (01) > watchdog (11) > software (10).
- Trigger response in any state, at the next edge:
  - state = HOLD, cnt = HOLD_CYCLES-1;
  - all three resets = 1, rst_done_o = 0;
  - rst_cause_o = cause of the winning trigger.
- rst_cause_o holds its value until the next trigger.
- States and transitions:
  - HOLD: cnt reloads while any trigger is active, otherwise decrements. Leaves for WAIT_LOCK at cnt == 0 with no trigger.
  - WAIT_LOCK: all resets asserted; stays at least one cycle. Leaves for REL_MEM when lock_i = 1: mem_rst_o = 0, cnt = STAGGER_CYCLES-1.
  - REL_MEM: decrements cnt. At 0, goes to REL_PERIPH: periph_rst_o = 0, cnt reloaded.
  - REL_PERIPH: decrements cnt. At 0, goes to RUN: cpu_rst_o = 0, rst_done_o = 1.
  - RUN: holds until a trigger occurs.
- Reset outputs come directly from flops (glitch-free). Only the transitions above ever deassert a domain reset.
- Counter width: $clog2 of max(HOLD_CYCLES, STAGGER_CYCLES), minimum 1 bit.

## Timing
- Reset values (wb_rst_i = 1): mem/periph/cpu_rst_o = 1, rst_done_o = 0, rst_cause_o = 00, state HOLD, synchronizer flops = 1 (deasserted).
- Edge numbering: edge 1 is the first edge at which wb_rst_i samples 0, with lock_i high.
  - mem_rst_o falls after edge HOLD_CYCLES+1.
  - periph_rst_o falls STAGGER_CYCLES edges later.
  - cpu_rst_o and rst_done_o change STAGGER_CYCLES edges after that.
- ext_rst_n_i adds SYNC_STAGES cycles of latency before it acts as a trigger. Pulses shorter than one clock may be missed.
- A trigger during REL_MEM, REL_PERIPH or RUN re-asserts every already-released reset at the next edge. Triggers are never deferred.
- sw_rst_req_i held high acts like a held trigger and extends HOLD.

## Configuration
- RST_SEQ_WDT_EN defined:
  - A watchdog counter runs only in RUN and is cleared on entry to RUN and on wdt_kick_i = 1.
  - When the counter reaches WDT_CYCLES-1 without a kick, it triggers with cause 11.
  - A kick in the same cycle as expiry wins, and no reset occurs.
- RST_SEQ_WDT_EN undefined:
  - No watchdog logic is built and wdt_kick_i is ignored; the port stays in place for a stable pinout.
  - Cause 11 is never produced.

## Test plan
- Power-on: HOLD=16, STAGGER=8, wb_rst_i high 4 cycles, lock_i = 1 → mem_rst_o falls after edge 17, periph after edge 25, cpu and rst_done_o after edge 33; rst_cause_o = 00.
- Late lock: lock_i rises 40 cycles after wb_rst_i release → mem_rst_o falls one edge after lock_i is sampled high, then the stagger spacing follows; rst_done_o stays 0 until then.
- Button in RUN: ext_rst_n_i low for 10 cycles → all resets high 2 edges after the fall; release sequence restarts 16 cycles after the synchronized rise; rst_cause_o = 01.
- Software and lock events:
  - sw_rst_req_i pulse while in REL_PERIPH → mem_rst_o re-asserts next edge, cause 10, full sequence repeats.
  - lock_i drops in RUN → cause 00.
- Simultaneous triggers: sw_rst_req_i and ext (synchronized) active in the same cycle → rst_cause_o = 01.
- RST_SEQ_WDT_EN with WDT_CYCLES=64:
  - no kicks → reset 64 cycles after RUN entry, cause 11;
  - kick every 50 cycles → rst_done_o stays 1 for 1000 cycles.
